// File: rtl/uintm_alu_pipe.sv
// uintm_alu_pipe: two-stage registered ALU front end (add/sub/mul/and/or/xor).
// Stage 1 registers the operation; stage 2 registers the modulo-2^BITS result.
// Both ends use valid/ready; one operation per cycle when unstalled.
module uintm_alu_pipe #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [BITS-1:0] in_x,
  input  logic [BITS-1:0] in_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_result,
  output logic [2:0]      out_op,
  output logic            out_err
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  logic            s1_valid;
  logic [2:0]      s1_op;
  logic [BITS-1:0] s1_x;
  logic [BITS-1:0] s1_y;
  logic            s2_valid;

  logic            s2_free;
  logic            s1_adv;
  logic            in_xfer;
  logic            out_xfer;

  logic [BITS-1:0] alu_res;
  logic            alu_err;

  // Stage handshake: in_ready looks through to out_ready (no skid buffer).
  always_comb begin
    s2_free   = !s2_valid || out_ready;
    s1_adv    = s1_valid && s2_free;
    in_ready  = !s1_valid || s2_free;
    in_xfer   = in_valid && in_ready;
    out_xfer  = s2_valid && out_ready;
    out_valid = s2_valid;
  end

  // Stage 1: capture operation on input transfer, release when it moves to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_x     <= in_x;
      s1_y     <= in_y;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ALU: results truncate to BITS; opcodes 6/7 flag an error with a zero result.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (s1_op)
      OP_ADD:  alu_res = s1_x + s1_y;
      OP_SUB:  alu_res = s1_x - s1_y;
      OP_MUL:  alu_res = s1_x * s1_y;
      OP_AND:  alu_res = s1_x & s1_y;
      OP_OR:   alu_res = s1_x | s1_y;
      OP_XOR:  alu_res = s1_x ^ s1_y;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Stage 2: load on advance; on output transfer only drop valid, payload stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      out_err    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      out_result <= alu_res;
      out_op     <= s1_op;
      out_err    <= alu_err;
    end else if (out_xfer) begin
      s2_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uintm_alu_pipe.sv
// Scoreboard bench for uintm_alu_pipe: the driver pushes expected results on
// each accepted input; the monitor pops and compares on each output transfer.
module tb_uintm_alu_pipe;

  localparam int unsigned BITS = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [BITS-1:0] in_x;
  logic [BITS-1:0] in_y;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_result;
  logic [2:0]      out_op;
  logic            out_err;

  typedef struct {
    logic [BITS-1:0] res;
    logic [2:0]      op;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int total;
  int bad;
  int popped;
  bit accepted;
  bit done;

  uintm_alu_pipe #(.BITS(BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [BITS-1:0] x,
                                 input logic [BITS-1:0] y);
    exp_t e;
    int unsigned xi;
    int unsigned yi;
    xi = x;
    yi = y;
    e.op  = op;
    e.err = 1'b0;
    case (op)
      3'd0: e.res = BITS'((xi + yi) % 256);
      3'd1: e.res = BITS'((xi + 256 - yi) % 256);
      3'd2: e.res = BITS'((xi * yi) % 256);
      3'd3: e.res = x & y;
      3'd4: e.res = x | y;
      3'd5: e.res = x ^ y;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus just after negedge; record acceptance before the edge.
  task automatic step(input bit v, input logic [2:0] op, input logic [BITS-1:0] x,
                      input logic [BITS-1:0] y, input bit ordy);
    in_valid  = v;
    in_op     = op;
    in_x      = x;
    in_y      = y;
    out_ready = ordy;
    #1;
    accepted = v && in_ready;
    if (accepted) exp_q.push_back(model(op, x, y));
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 3'd0, '0, '0, 1'b1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: compare every output transfer against the scoreboard, and check stall stability.
  initial begin : monitor
    exp_t e;
    bit stalled;
    logic [BITS-1:0] p_res;
    logic [2:0] p_op;
    logic p_err;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_result", int'(out_result), int'(p_res));
          check("hold_op", int'(out_op), int'(p_op));
          check("hold_err", int'(out_err), int'(p_err));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", int'(out_result), -1);
          end else begin
            e = exp_q.pop_front();
            popped++;
            check("result", int'(out_result), int'(e.res));
            check("op", int'(out_op), int'(e.op));
            check("err", int'(out_err), int'(e.err));
          end
        end
        stalled = out_valid && !out_ready;
        p_res = out_result;
        p_op  = out_op;
        p_err = out_err;
      end
    end
  end

  initial begin : driver
    int acc;
    int cyc;
    total = 0; bad = 0; popped = 0; done = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_result", int'(out_result), 0);
    check("rst_out_op", int'(out_op), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // add 200+255 -> 199, visible two cycles after acceptance
    step(1'b1, 3'd0, 8'd200, 8'd255, 1'b1);
    check("add_accept", int'(accepted), 1);
    check("lat_not_yet", int'(out_valid), 0);
    step(1'b0, 3'd0, '0, '0, 1'b1);
    check("lat_visible", int'(out_valid), 1);
    check("lat_result", int'(out_result), 199);
    check("idle_in_ready", int'(in_ready), 1);
    drain(10);

    // back-to-back with directed expectations
    begin
      logic [2:0] ops [5];
      logic [7:0] xs [5];
      logic [7:0] ys [5];
      logic [7:0] rs [5];
      ops = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd4};
      xs  = '{8'd3, 8'd16, 8'hA5, 8'hF0, 8'h81};
      ys  = '{8'd5, 8'd17, 8'h0F, 8'h3C, 8'h18};
      rs  = '{8'd254, 8'd16, 8'hAA, 8'h30, 8'h99};
      for (int k = 0; k < 7; k++) begin
        if (k >= 2) begin
          check("nobubble_valid", int'(out_valid), 1);
          check("b2b_result", int'(out_result), int'(rs[k-2]));
        end
        if (k < 5) begin
          step(1'b1, ops[k], xs[k], ys[k], 1'b1);
          check("b2b_accept", int'(accepted), 1);
        end else begin
          step(1'b0, 3'd0, '0, '0, 1'b1);
        end
      end
    end
    drain(10);

    // illegal opcode then legal add
    step(1'b1, 3'd6, 8'd7, 8'd9, 1'b1);
    step(1'b1, 3'd0, 8'd1, 8'd1, 1'b1);
    check("illegal_err", int'(out_err), 1);
    check("illegal_op", int'(out_op), 6);
    check("illegal_result", int'(out_result), 0);
    step(1'b0, 3'd0, '0, '0, 1'b1);
    check("post_illegal_err", int'(out_err), 0);
    check("post_illegal_result", int'(out_result), 2);
    drain(10);

    // backpressure: two fill the pipe, third is refused until out_ready rises
    step(1'b1, 3'd0, 8'd1, 8'd2, 1'b0);
    check("bp_acc1", int'(accepted), 1);
    step(1'b1, 3'd0, 8'd3, 8'd4, 1'b0);
    check("bp_acc2", int'(accepted), 1);
    step(1'b1, 3'd0, 8'd5, 8'd6, 1'b0);
    check("bp_refuse3", int'(accepted), 0);
    check("bp_held", int'(out_result), 3);
    step(1'b1, 3'd0, 8'd5, 8'd6, 1'b0);
    check("bp_refuse3b", int'(accepted), 0);
    step(1'b1, 3'd0, 8'd5, 8'd6, 1'b1);
    check("bp_acc3", int'(accepted), 1);
    drain(10);
    check("bp_popped", popped, 11);

    // reset with two operations in flight
    step(1'b1, 3'd0, 8'd9, 8'd9, 1'b0);
    step(1'b1, 3'd0, 8'd8, 8'd8, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    step(1'b1, 3'd2, 8'd4, 8'd4, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) step(1'b0, 3'd0, '0, '0, 1'b1);
    check("no_stale", int'(out_valid), 0);

    // random soak
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), ($urandom_range(0, 3) != 0));
      if (accepted) acc++;
      cyc++;
    end
    check("soak_count", acc, 10000);
    drain(50);

    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uintm_alu_pipe.md
Name: uintm_alu_pipe

Overview:
- Two-stage registered ALU front end for the uintm arithmetic/bitwise units (add, sub, mul, and, or, xor).
- Accepts opcode plus operand pairs over a valid/ready handshake and registers them in stage 1.
- Computes the selected modulo-2^BITS result combinationally from the stage-1 registers, registers it in stage 2, and presents it downstream over a valid/ready handshake.
- Sustains one operation per cycle and stalls correctly under backpressure.

Parameters:
- BITS, 8, operand and result width; all arithmetic is modulo 2^BITS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a valid operation
- in_ready  output  1  block accepts the operation this cycle
- in_op  input  3  opcode: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6-7 illegal
- in_x  input  BITS  operand x
- in_y  input  BITS  operand y
- out_valid  output  1  out_result, out_op and out_err are valid
- out_ready  input  1  downstream consumes the result this cycle
- out_result  output  BITS  registered result
- out_op  output  3  opcode that produced out_result
- out_err  output  1  1 when out_op was illegal

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_op=0, out_err=0.
  - Stage-1 operand registers also clear to 0.
  - rst has priority over every handshake in the same cycle.
  - Any in-flight operations are discarded; no output is produced for them.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid and the input payload may change only after a transfer; the block does not depend on this for correctness.
- Stage control:
  - s2_free = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_free
  - in_ready = !s1_valid || s2_free
  - in_ready depends combinationally on out_ready; there is no skid buffer. in_ready is 1 during reset-deasserted idle.
- Stage 1: on input transfer, capture in_op/in_x/in_y and set s1_valid=1. Otherwise, if s1_adv, clear s1_valid=0. If stalled, hold.
- Compute from stage-1 registers, each truncated to BITS:
  - add = x+y
  - sub = x-y (two's-complement wrap)
  - mul = low BITS bits of x*y
  - and, or, xor: bitwise
  - Ops 6/7: result=0, err=1. Legal ops: err=0.
- Stage 2:
  - If s1_adv: load result/op/err and set s2_valid=1.
  - Else if the output transfers: clear s2_valid=0 and keep payload registers unchanged.
  - Else hold; payload is stable while out_valid && !out_ready.
- Simultaneous events: input transfer, s1_adv and output transfer may all occur in one cycle. This is the full-throughput case; no bubble is inserted.
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+1 (2 cycles accept-to-visible), given out_ready was 1.
- Capacity: at most 2 operations in flight. With out_ready=0, in_ready falls to 0 once both stages are full.
- Ordering: strictly in order; no drops and no duplicates.
- out_valid = s2_valid.

Test Plan (BITS=8):
- Reset, then out_ready=1, issue add 200,255 -> out_valid two cycles later; out_result=199, out_op=0, out_err=0; in_ready stays 1.
- Back-to-back ops sub 3,5; mul 16,17; xor 0xA5,0x0F; and 0xF0,0x3C; or 0x81,0x18 on consecutive cycles -> results 254, 16, 0xAA, 0x30, 0x99 on consecutive cycles, in order, no bubbles.
- Illegal op 6 with 7,9 -> out_result=0, out_err=1, out_op=6; the following legal add 1,1 gives 2 with out_err=0.
- Backpressure: out_ready=0 while issuing add 1,2; add 3,4; add 5,6 -> first two accepted, in_ready=0 on the third, out_result=3 held stable. Then out_ready=1 -> outputs 3, 7, 11 in order, third accepted the cycle out_ready rises.
- Reset mid-operation: two ops in flight with out_ready=0, assert rst one cycle -> out_valid=0, in_ready=1 next cycle; no stale result ever appears afterwards.
- Random soak: 10k random ops with random in_valid/out_ready -> scoreboard matches a modulo-256 reference model exactly and in order.
